morse_keyer: RTL and testbench

MORSE_KEYER -- requirements
Module: morse_keyer

---
 rtl/morse_keyer.sv | 147 ++++++++++++++
 tb/tb_morse_keyer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/morse_keyer.sv
// Morse keyer: plays one captured character (or a word space) on key_out with exact unit timing.
// Optional gated sidetone on tone_out when MORSE_KEYER_TONE_EN is defined; otherwise tone_out is 0.
module morse_keyer #(
  parameter int unsigned CLKS_PER_UNIT = 1200000,
  parameter int unsigned TONE_HALF     = 6000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] morse,
  input  logic [2:0] length,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       key_out,
  output logic       busy,
  output logic       done,
  output logic       tone_out
);

  localparam int CW = 26;

  localparam logic [CW-1:0] UNIT_END = CW'(CLKS_PER_UNIT - 1);
  localparam logic [CW-1:0] DASH_END = CW'(3 * CLKS_PER_UNIT - 1);
  // The done/IDLE cycle is the final cycle of a trailing gap, hence the -2.
  localparam logic [CW-1:0] CHAR_END = CW'(3 * CLKS_PER_UNIT - 2);
  localparam logic [CW-1:0] WORD_END = CW'(4 * CLKS_PER_UNIT - 2);

  if (CLKS_PER_UNIT < 2 || CLKS_PER_UNIT > 32'h00FF_FFFF) begin : g_bad_unit
    $error("morse_keyer: CLKS_PER_UNIT out of range");
  end
  if (TONE_HALF < 1) begin : g_bad_tone
    $error("morse_keyer: TONE_HALF must be at least 1");
  end

  typedef enum logic [2:0] {
    IDLE,
    MARK,
    GAP,
    CHARGAP,
    WORDGAP
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2:0]      idx;
  logic [7:0]      pat;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      pat      <= '0;
      key_out  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      in_ready <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          cnt      <= '0;
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            pat      <= morse;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            if (length != 3'd0) begin
              state   <= MARK;
              idx     <= length - 3'd1;
              key_out <= 1'b1;
            end else begin
              state   <= WORDGAP;
              key_out <= 1'b0;
            end
          end
        end

        MARK: begin
          if (cnt == (pat[idx] ? DASH_END : UNIT_END)) begin
            cnt     <= '0;
            key_out <= 1'b0;
            state   <= (idx != 3'd0) ? GAP : CHARGAP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        GAP: begin
          if (cnt == UNIT_END) begin
            cnt     <= '0;
            idx     <= idx - 3'd1;
            key_out <= 1'b1;
            state   <= MARK;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        CHARGAP, WORDGAP: begin
          if (cnt == ((state == CHARGAP) ? CHAR_END : WORD_END)) begin
            cnt      <= '0;
            state    <= IDLE;
            done     <= 1'b1;
            in_ready <= 1'b1;
            busy     <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        default: begin
          state    <= IDLE;
          cnt      <= '0;
          key_out  <= 1'b0;
          busy     <= 1'b0;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

`ifdef MORSE_KEYER_TONE_EN
  localparam int TW = (TONE_HALF > 2) ? $clog2(TONE_HALF) : 1;
  localparam logic [TW-1:0] TONE_LAST = TW'(TONE_HALF - 1);

  logic [TW-1:0] tone_div;
  logic          tone_q;

  // Divider restarts on every mark, so each mark begins with the same phase.
  always_ff @(posedge clk) begin
    if (!rst_n || !key_out) begin
      tone_div <= '0;
      tone_q   <= 1'b0;
    end else if (tone_div == TONE_LAST) begin
      tone_div <= '0;
      tone_q   <= ~tone_q;
    end else begin
      tone_div <= tone_div + TW'(1);
    end
  end

  assign tone_out = tone_q & key_out;
`else
  assign tone_out = 1'b0;
`endif

endmodule

// File: tb/tb_morse_keyer.sv
// Self-checking bench for morse_keyer: directed characters plus random ones against a
// per-cycle waveform model built from the dot/dash/gap timing rules.
module tb_morse_keyer;

  localparam int U  = 4;
  localparam int TH = 2;

  logic       clk;
  logic       rst_n;
  logic [7:0] morse;
  logic [2:0] length;
  logic       in_valid;
  logic       in_ready;
  logic       key_out;
  logic       busy;
  logic       done;
  logic       tone_out;

  int checks = 0;
  int errors = 0;

  morse_keyer #(.CLKS_PER_UNIT(U), .TONE_HALF(TH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .morse    (morse),
    .length   (length),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .key_out  (key_out),
    .busy     (busy),
    .done     (done),
    .tone_out (tone_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag, input logic rdy);
    check_output({tag, " key"}, key_out, 1'b0);
    check_output({tag, " busy"}, busy, 1'b0);
    check_output({tag, " done"}, done, 1'b0);
    check_output({tag, " ready"}, in_ready, rdy);
    check_output({tag, " tone"}, tone_out, 1'b0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Expected key waveform for the cycles following a transfer.
  task automatic build_expected(input logic [7:0] m, input logic [2:0] len, output bit q[$]);
    q.delete();
    if (len == 3'd0) begin
      repeat (4 * U) q.push_back(1'b0);
    end else begin
      for (int s = int'(len) - 1; s >= 0; s--) begin
        repeat (m[s] ? 3 * U : U) q.push_back(1'b1);
        repeat (s > 0 ? U : 3 * U) q.push_back(1'b0);
      end
    end
  endtask

  function automatic logic tone_model(input bit on, input int offset);
`ifdef MORSE_KEYER_TONE_EN
    return on && (((offset / TH) % 2) == 1);
`else
    return 1'b0;
`endif
  endfunction

  // Transfer one character, then follow it cycle by cycle; abort_at>=0 asserts reset there.
  task automatic apply_stimulus(input string tag, input logic [7:0] m, input logic [2:0] len,
                                input bit noise, input int abort_at);
    bit q[$];
    int run;
    build_expected(m, len, q);
    check_output({tag, " ready before transfer"}, in_ready, 1'b1);
    morse    = m;
    length   = len;
    in_valid = 1'b1;
    next_cycle();
    in_valid = 1'b0;
    run = 0;
    for (int k = 0; k < q.size(); k++) begin
      run = (q[k] && k > 0 && q[k-1]) ? run + 1 : 0;
      check_output($sformatf("%s key c%0d", tag, k + 1), key_out, q[k]);
      check_output($sformatf("%s busy c%0d", tag, k + 1), busy, k < q.size() - 1);
      check_output($sformatf("%s done c%0d", tag, k + 1), done, k == q.size() - 1);
      check_output($sformatf("%s ready c%0d", tag, k + 1), in_ready, k == q.size() - 1);
      check_output($sformatf("%s tone c%0d", tag, k + 1), tone_out, tone_model(q[k], run));
      if (k == abort_at) begin
        in_valid = 1'b0;
        rst_n    = 1'b0;
        next_cycle();
        check_idle({tag, " abort"}, 1'b0);
        next_cycle();
        check_idle({tag, " abort hold"}, 1'b0);
        rst_n = 1'b1;
        next_cycle();
        check_idle({tag, " abort release"}, 1'b1);
        return;
      end
      if (k < q.size() - 1) begin
        in_valid = noise ? 1'($urandom) : 1'b0;
        morse    = 8'($urandom);
        length   = 3'($urandom);
        next_cycle();
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] rm;
    logic [2:0] rl;
    int gap;

    rst_n    = 1'b0;
    in_valid = 1'b0;
    morse    = 8'h00;
    length   = 3'd0;
    repeat (3) begin
      next_cycle();
      check_idle("reset", 1'b0);
    end
    rst_n = 1'b1;
    next_cycle();
    check_idle("after reset", 1'b1);

    $display("[TB] E");
    apply_stimulus("E", 8'h00, 3'd1, 1'b0, -1);
    next_cycle();
    check_idle("idle after E", 1'b1);

    $display("[TB] A with ignored in_valid pulses");
    apply_stimulus("A", 8'h01, 3'd2, 1'b1, -1);
    next_cycle();
    check_idle("idle after A", 1'b1);

    $display("[TB] T then word space back-to-back");
    apply_stimulus("T", 8'h01, 3'd1, 1'b0, -1);
    apply_stimulus("space", 8'h00, 3'd0, 1'b0, -1);
    next_cycle();
    check_idle("idle after space", 1'b1);

    $display("[TB] B aborted by reset in second symbol");
    apply_stimulus("B", 8'h08, 3'd4, 1'b0, 17);
    apply_stimulus("E after abort", 8'h00, 3'd1, 1'b0, -1);

    $display("[TB] random characters");
    for (int n = 0; n < 10; n++) begin
      rm  = 8'($urandom);
      rl  = 3'($urandom_range(0, 7));
      gap = $urandom_range(0, 2);
      apply_stimulus($sformatf("rand%0d", n), rm, rl, 1'($urandom), -1);
      for (int g = 0; g < gap; g++) begin
        next_cycle();
        check_idle($sformatf("rand%0d idle", n), 1'b1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
